mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/mem_arb_timer.sv | 29 ++
 rtl/mem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  localparam int unsigned NUM_REQ       = 2;
  localparam int unsigned TIMER_W       = 8;
  localparam int unsigned TIMEOUT_LIMIT = 255;
  localparam logic [31:0] POISON        = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RESP    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  // Round-robin pick: on a tie the requester not served last wins.
  function automatic logic rr_pick(input logic [NUM_REQ-1:0] pend, input logic last);
    if (pend == 2'b11) begin
      return ~last;
    end
    return pend[1];
  endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// GRANT watchdog: counts cycles while enabled, flags the last allowed cycle.
// Present only when MEM_ARB_TIMEOUT_EN is defined.
`ifdef MEM_ARB_TIMEOUT_EN
module mem_arb_timer
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic expired_c
);

  logic [TIMER_W-1:0] count;

  // Cycle counter, cleared whenever the arbiter is not waiting on the RAM
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (enable) begin
      count <= count + TIMER_W'(1);
    end else begin
      count <= '0;
    end
  end

  assign expired_c = enable && (count == TIMER_W'(TIMEOUT_LIMIT - 1));

endmodule
`endif

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port RAM.
// Port 0 is the CPU, port 1 the DMA/debug loader.
// Optional MEM_ARB_TIMEOUT_EN: abort a GRANT that sees no RAM ack in 255
// cycles, returning poison data and pulsing timeoutErr.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  // requester 0 (CPU)
  input  logic              rq0_readReq,
  input  logic              rq0_writeReq,
  input  logic [ADDR_W-1:0] rq0_address,
  input  logic [DATA_W-1:0] rq0_dataOut,
  output logic              rq0_readAck,
  output logic              rq0_writeAck,
  output logic [DATA_W-1:0] rq0_dataIn,
  // requester 1 (DMA/debug loader)
  input  logic              rq1_readReq,
  input  logic              rq1_writeReq,
  input  logic [ADDR_W-1:0] rq1_address,
  input  logic [DATA_W-1:0] rq1_dataOut,
  output logic              rq1_readAck,
  output logic              rq1_writeAck,
  output logic [DATA_W-1:0] rq1_dataIn,
  // RAM side
  output logic [ADDR_W-1:0] ramAddress,
  output logic [DATA_W-1:0] ramOut,
  output logic              readReq,
  output logic              writeReq,
  input  logic [DATA_W-1:0] ramIn,
  input  logic              readAck,
  input  logic              writeAck,
`ifdef MEM_ARB_TIMEOUT_EN
  output logic              timeoutErr,
`endif
  output logic [1:0]        grantOwner
);

  state_t             state;
  logic               owner;
  logic               busy;
  logic               last_served;
  logic               is_write;

  logic [NUM_REQ-1:0] pend_c;
  logic               win_c;
  logic               win_rd_c;
  logic [ADDR_W-1:0]  win_addr_c;
  logic [DATA_W-1:0]  win_data_c;
  logic               ack_match_c;
  logic               timeout_c;
  logic [DATA_W-1:0]  resp_data_c;

  // Winner selection for the IDLE grant decision
  assign pend_c     = {rq1_readReq | rq1_writeReq, rq0_readReq | rq0_writeReq};
  assign win_c      = rr_pick(pend_c, last_served);
  assign win_rd_c   = win_c ? rq1_readReq : rq0_readReq;
  assign win_addr_c = win_c ? rq1_address : rq0_address;
  assign win_data_c = win_c ? rq1_dataOut : rq0_dataOut;

  // Only the ack matching the outstanding RAM request completes it
  assign ack_match_c = is_write ? writeAck : readAck;

`ifdef MEM_ARB_TIMEOUT_EN
  mem_arb_timer u_timer (
    .clk       (clk),
    .reset     (reset),
    .enable    (state == GRANT),
    .expired_c (timeout_c)
  );
  assign resp_data_c = ack_match_c ? ramIn : DATA_W'(POISON);
`else
  assign timeout_c   = 1'b0;
  assign resp_data_c = ramIn;
`endif

  assign grantOwner = {busy, owner};

  // Arbiter FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      owner        <= 1'b1;
      busy         <= 1'b0;
      last_served  <= 1'b1;
      is_write     <= 1'b0;
      ramAddress   <= '0;
      ramOut       <= '0;
      readReq      <= 1'b0;
      writeReq     <= 1'b0;
      rq0_readAck  <= 1'b0;
      rq0_writeAck <= 1'b0;
      rq1_readAck  <= 1'b0;
      rq1_writeAck <= 1'b0;
      rq0_dataIn   <= '0;
      rq1_dataIn   <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      timeoutErr   <= 1'b0;
`endif
    end else begin
      rq0_readAck  <= 1'b0;
      rq0_writeAck <= 1'b0;
      rq1_readAck  <= 1'b0;
      rq1_writeAck <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      timeoutErr   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (|pend_c) begin
            owner      <= win_c;
            busy       <= 1'b1;
            ramAddress <= win_addr_c;
            state      <= GRANT;
            if (win_rd_c) begin
              is_write <= 1'b0;
              readReq  <= 1'b1;
            end else begin
              is_write <= 1'b1;
              writeReq <= 1'b1;
              ramOut   <= win_data_c;
            end
          end
        end
        GRANT: begin
          if (ack_match_c || timeout_c) begin
            readReq     <= 1'b0;
            writeReq    <= 1'b0;
            last_served <= owner;
            state       <= RESP;
`ifdef MEM_ARB_TIMEOUT_EN
            timeoutErr  <= ~ack_match_c;
`endif
            if (is_write) begin
              if (owner) rq1_writeAck <= 1'b1;
              else       rq0_writeAck <= 1'b1;
            end else if (owner) begin
              rq1_readAck <= 1'b1;
              rq1_dataIn  <= resp_data_c;
            end else begin
              rq0_readAck <= 1'b1;
              rq0_dataIn  <= resp_data_c;
            end
          end
        end
        RESP: begin
          state <= RELEASE;
        end
        RELEASE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed table, hand sequences, randomized traffic
// against a transaction-level arbitration/memory model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rq_rd [2];
  logic        rq_wr [2];
  logic [7:0]  rq_addr [2];
  logic [31:0] rq_wdata [2];
  logic        rq0_readAck, rq0_writeAck, rq1_readAck, rq1_writeAck;
  logic [31:0] rq0_dataIn, rq1_dataIn;
  logic [7:0]  ramAddress;
  logic [31:0] ramOut, ramIn;
  logic        readReq, writeReq, readAck, writeAck;
  logic [1:0]  grantOwner;
`ifdef MEM_ARB_TIMEOUT_EN
  logic        timeoutErr;
`endif

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .rq0_readReq(rq_rd[0]), .rq0_writeReq(rq_wr[0]), .rq0_address(rq_addr[0]),
    .rq0_dataOut(rq_wdata[0]), .rq0_readAck(rq0_readAck), .rq0_writeAck(rq0_writeAck),
    .rq0_dataIn(rq0_dataIn),
    .rq1_readReq(rq_rd[1]), .rq1_writeReq(rq_wr[1]), .rq1_address(rq_addr[1]),
    .rq1_dataOut(rq_wdata[1]), .rq1_readAck(rq1_readAck), .rq1_writeAck(rq1_writeAck),
    .rq1_dataIn(rq1_dataIn),
    .ramAddress(ramAddress), .ramOut(ramOut), .readReq(readReq), .writeReq(writeReq),
    .ramIn(ramIn), .readAck(readAck), .writeAck(writeAck),
`ifdef MEM_ARB_TIMEOUT_EN
    .timeoutErr(timeoutErr),
`endif
    .grantOwner(grantOwner)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic rd_ack(input int p);
    return (p == 0) ? rq0_readAck : rq1_readAck;
  endfunction
  function automatic logic wr_ack(input int p);
    return (p == 0) ? rq0_writeAck : rq1_writeAck;
  endfunction
  function automatic logic [31:0] data_in(input int p);
    return (p == 0) ? rq0_dataIn : rq1_dataIn;
  endfunction

  // ---------------- RAM responder ----------------
  logic [31:0] mem [256];
  int  fixed_lat = 0;
  bit  ram_dead = 0;
  bit  stray = 0;
  int  unstable = 0;

  initial begin : responder
    int cnt;
    int lat;
    logic [7:0]  a0;
    logic [31:0] d0;
    logic        k0;
    readAck = 1'b0; writeAck = 1'b0; ramIn = '0; cnt = 0; lat = 1;
    a0 = '0; d0 = '0; k0 = 1'b0;
    forever begin
      @(negedge clk);
      readAck = 1'b0; writeAck = 1'b0; ramIn = $urandom;
      if (stray) begin
        readAck = 1'b1; writeAck = 1'b1; stray = 0;
      end else if (readReq || writeReq) begin
        cnt++;
        if (cnt == 1) begin
          a0 = ramAddress; d0 = ramOut; k0 = writeReq;
        end else if (ramAddress !== a0 || writeReq !== k0 || (k0 && ramOut !== d0)) begin
          unstable++;
        end
        if (!ram_dead && cnt == lat) begin
          if (writeReq) begin
            mem[ramAddress] = ramOut; writeAck = 1'b1;
          end else begin
            ramIn = mem[ramAddress]; readAck = 1'b1;
          end
        end
      end else begin
        cnt = 0;
        lat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(4, 1));
      end
    end
  end

  // ---------------- monitor ----------------
  typedef struct {int port; bit wr; logic [31:0] data; bit own;} ev_t;
  ev_t evlog[$];
  int both_viol = 0, nonowner = 0, tmo_pulses = 0;
  int gap = 0, min_gap = 1000;
  bit seen_req = 0, prev_req = 0;

  initial begin : monitor
    forever begin
      @(negedge clk);
      begin
        int nack;
        nack = 0;
        for (int p = 0; p < 2; p++) begin
          if (rd_ack(p) === 1'b1) begin
            evlog.push_back('{p, 1'b0, data_in(p), grantOwner[0]});
            nack++;
            if (p != int'(grantOwner[0])) nonowner++;
          end
          if (wr_ack(p) === 1'b1) begin
            evlog.push_back('{p, 1'b1, 32'h0, grantOwner[0]});
            nack++;
            if (p != int'(grantOwner[0])) nonowner++;
          end
        end
        if (nack > 1) nonowner++;
      end
      if (readReq === 1'b1 && writeReq === 1'b1) both_viol++;
      if (readReq === 1'b1 || writeReq === 1'b1) begin
        if (!prev_req && seen_req && gap < min_gap) min_gap = gap;
        seen_req = 1; gap = 0; prev_req = 1;
      end else begin
        gap++; prev_req = 0;
      end
`ifdef MEM_ARB_TIMEOUT_EN
      if (timeoutErr === 1'b1) tmo_pulses++;
`endif
    end
  end

  // ---------------- requester engine ----------------
  typedef struct {bit rd; bit wr; logic [7:0] addr; logic [31:0] data;} op_t;
  op_t opq0[$], opq1[$];

  // Each requester holds its level request until acked, then presents the next op.
  task automatic run_engine(input string tag);
    bit prd [2];
    bit pwr [2];
    int cyc;
    op_t o;
    bit done;
    prd[0] = 0; prd[1] = 0; pwr[0] = 0; pwr[1] = 0;
    cyc = 0; done = 0;
    while (!done && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      for (int p = 0; p < 2; p++) begin
        if (rd_ack(p) === 1'b1) prd[p] = 0;
        if (wr_ack(p) === 1'b1) pwr[p] = 0;
        if (!prd[p] && !pwr[p]) begin
          if (p == 0 && opq0.size() > 0) begin
            o = opq0.pop_front();
            prd[p] = o.rd; pwr[p] = o.wr; rq_addr[p] = o.addr; rq_wdata[p] = o.data;
          end else if (p == 1 && opq1.size() > 0) begin
            o = opq1.pop_front();
            prd[p] = o.rd; pwr[p] = o.wr; rq_addr[p] = o.addr; rq_wdata[p] = o.data;
          end
        end
        rq_rd[p] = prd[p]; rq_wr[p] = pwr[p];
      end
      done = !prd[0] && !pwr[0] && !prd[1] && !pwr[1] && opq0.size() == 0 &&
             opq1.size() == 0 && grantOwner[1] == 1'b0;
    end
    check({tag, "_finished"}, 64'(done), 64'd1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    rq_rd[0] = 0; rq_rd[1] = 0; rq_wr[0] = 0; rq_wr[1] = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {int port; bit wr; logic [7:0] addr; logic [31:0] wdata; int lat; logic [31:0] exp;} vec_t;

  task automatic single_txn(input int idx, input vec_t v);
    int base, n, p;
    string nm;
    p = v.port;
    nm = $sformatf("vec%0d", idx);
    fixed_lat = v.lat;
    base = evlog.size();
    @(negedge clk);
    rq_addr[p] = v.addr; rq_wdata[p] = v.wdata; rq_rd[p] = !v.wr; rq_wr[p] = v.wr;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(rd_ack(p) === 1'b1 || wr_ack(p) === 1'b1) && n < 600);
    rq_rd[p] = 0; rq_wr[p] = 0;
    check({nm, "_latency"}, 64'(n), 64'(v.lat + 1));
    check({nm, "_ack_kind"}, 64'(v.wr ? wr_ack(p) : rd_ack(p)), 64'd1);
    check({nm, "_other_port_quiet"}, 64'(rd_ack(1 - p) | wr_ack(1 - p)), 64'd0);
    if (!v.wr) check({nm, "_data"}, 64'(data_in(p)), 64'(v.exp));
    @(negedge clk);
    check({nm, "_single_pulse"}, 64'(rd_ack(p) | wr_ack(p)), 64'd0);
    @(negedge clk);
    check({nm, "_owner_idle"}, 64'(grantOwner), 64'(p));
    if (!v.wr) check({nm, "_data_held"}, 64'(data_in(p)), 64'(v.exp));
    check({nm, "_ack_count"}, 64'(evlog.size() - base), 64'd1);
  endtask

  // ---------------- reference model ----------------
  typedef struct {bit wr; logic [7:0] addr; logic [31:0] data;} cmp_t;
  typedef struct {int port; bit wr; logic [31:0] data;} exp_t;
  cmp_t x0[$], x1[$];
  exp_t expq[$];
  logic [31:0] mm [256];
  int model_last = 1;

  // Serve pending requesters: alternate when both have work, else whoever has it.
  task automatic model_run();
    cmp_t c;
    int p;
    while (x0.size() > 0 || x1.size() > 0) begin
      if (x0.size() > 0 && x1.size() > 0) p = 1 - model_last;
      else p = (x0.size() > 0) ? 0 : 1;
      c = (p == 0) ? x0.pop_front() : x1.pop_front();
      if (c.wr) begin
        mm[c.addr] = c.data;
        expq.push_back('{p, 1'b1, 32'h0});
      end else begin
        expq.push_back('{p, 1'b0, mm[c.addr]});
      end
      model_last = p;
    end
  endtask

  task automatic gen_ops(input int port, input int n);
    op_t o;
    int k;
    for (int i = 0; i < n; i++) begin
      k = int'($urandom_range(2, 0));
      o.rd = (k != 1); o.wr = (k != 0);
      o.addr = 8'($urandom_range(15, 0));
      o.data = $urandom;
      if (port == 0) opq0.push_back(o); else opq1.push_back(o);
      if (o.rd) begin
        if (port == 0) x0.push_back('{1'b0, o.addr, 32'h0}); else x1.push_back('{1'b0, o.addr, 32'h0});
      end
      if (o.wr) begin
        if (port == 0) x0.push_back('{1'b1, o.addr, o.data}); else x1.push_back('{1'b1, o.addr, o.data});
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vec_t tbl [8];
    int base;
    int n, hi;
    int order [6];

    tbl[0] = '{0, 1'b0, 8'h10, 32'h0,        2, 32'h12345678};
    tbl[1] = '{1, 1'b1, 8'h20, 32'hCAFEF00D, 3, 32'h0};
    tbl[2] = '{1, 1'b0, 8'h20, 32'h0,        1, 32'hCAFEF00D};
    tbl[3] = '{0, 1'b0, 8'h20, 32'h0,        4, 32'hCAFEF00D};
    tbl[4] = '{0, 1'b1, 8'hFF, 32'h00000001, 1, 32'h0};
    tbl[5] = '{1, 1'b0, 8'hFF, 32'h0,        2, 32'h00000001};
    tbl[6] = '{0, 1'b1, 8'h00, 32'hFFFFFFFF, 2, 32'h0};
    tbl[7] = '{0, 1'b0, 8'h00, 32'h0,        1, 32'hFFFFFFFF};
    order = '{0, 1, 0, 1, 0, 1};

    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[8'h10] = 32'h12345678;
    mem[8'h20] = 32'h0BADCAFE;
    for (int p = 0; p < 2; p++) begin
      rq_rd[p] = 0; rq_wr[p] = 0; rq_addr[p] = '0; rq_wdata[p] = '0;
    end

    // reset state
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_readReq", 64'(readReq), 64'd0);
    check("rst_writeReq", 64'(writeReq), 64'd0);
    check("rst_acks", 64'({rq0_readAck, rq0_writeAck, rq1_readAck, rq1_writeAck}), 64'd0);
    check("rst_ramAddress", 64'(ramAddress), 64'd0);
    check("rst_ramOut", 64'(ramOut), 64'd0);
    check("rst_dataIn0", 64'(rq0_dataIn), 64'd0);
    check("rst_dataIn1", 64'(rq1_dataIn), 64'd0);
    check("rst_grantOwner", 64'(grantOwner), 64'd1);
`ifdef MEM_ARB_TIMEOUT_EN
    check("rst_timeoutErr", 64'(timeoutErr), 64'd0);
`endif
    reset = 1'b1;

    // stray RAM acks while idle are ignored
    base = evlog.size();
    stray = 1;
    repeat (3) @(negedge clk);
    check("stray_no_ack", 64'(evlog.size() - base), 64'd0);
    check("stray_still_idle", 64'(grantOwner), 64'd1);
    check("stray_no_ram_req", 64'(readReq | writeReq), 64'd0);

    // simultaneous tie right after reset: port 0 first
    fixed_lat = 2;
    base = evlog.size();
    min_gap = 1000;
    opq0.push_back('{1'b1, 1'b0, 8'h10, 32'h0});
    opq1.push_back('{1'b1, 1'b0, 8'h20, 32'h0});
    run_engine("tie");
    check("tie_count", 64'(evlog.size() - base), 64'd2);
    if (evlog.size() - base == 2) begin
      check("tie_first_port", 64'(evlog[base].port), 64'd0);
      check("tie_second_port", 64'(evlog[base + 1].port), 64'd1);
      check("tie_first_data", 64'(evlog[base].data), 64'h12345678);
      check("tie_second_data", 64'(evlog[base + 1].data), 64'h0BADCAFE);
    end
    check("tie_gap_ge2", 64'(min_gap >= 2), 64'd1);

    // directed single transactions
    for (int i = 0; i < 8; i++) single_txn(i, tbl[i]);

    // fairness under continuous requests
    do_reset();
    fixed_lat = 0;
    base = evlog.size();
    for (int i = 0; i < 3; i++) begin
      opq0.push_back('{1'b1, 1'b0, 8'h10, 32'h0});
      opq1.push_back('{1'b0, 1'b1, 8'(8'h30 + i), 32'(i)});
    end
    run_engine("fair");
    check("fair_count", 64'(evlog.size() - base), 64'd6);
    if (evlog.size() - base == 6) begin
      for (int i = 0; i < 6; i++) begin
        check($sformatf("fair_order%0d", i), 64'(evlog[base + i].port), 64'(order[i]));
        check($sformatf("fair_owner%0d", i), 64'(evlog[base + i].own), 64'(order[i]));
      end
    end

    // reset in the middle of GRANT
    ram_dead = 1;
    @(negedge clk);
    rq_addr[0] = 8'h44; rq_rd[0] = 1;
    repeat (3) @(negedge clk);
    check("midrst_grant_active", 64'(readReq), 64'd1);
    base = evlog.size();
    reset = 1'b0;
    rq_rd[0] = 0;
    @(negedge clk);
    check("midrst_readReq_drop", 64'(readReq), 64'd0);
    check("midrst_idle", 64'(grantOwner), 64'd1);
    check("midrst_no_ack", 64'({rq0_readAck, rq0_writeAck, rq1_readAck, rq1_writeAck}), 64'd0);
    reset = 1'b1;
    ram_dead = 0;
    repeat (2) @(negedge clk);
    check("midrst_no_ack_later", 64'(evlog.size() - base), 64'd0);

`ifdef MEM_ARB_TIMEOUT_EN
    // RAM never answers: watchdog completes the read with poison
    begin
      int t0;
      ram_dead = 1;
      t0 = tmo_pulses;
      @(negedge clk);
      rq_addr[0] = 8'h55; rq_rd[0] = 1;
      n = 0; hi = 0;
      do begin
        @(negedge clk);
        n++;
        if (readReq === 1'b1) hi++;
      end while (rq0_readAck !== 1'b1 && n < 400);
      rq_rd[0] = 0;
      check("tmo_req_cycles", 64'(hi), 64'd255);
      check("tmo_ack", 64'(rq0_readAck), 64'd1);
      check("tmo_poison", 64'(rq0_dataIn), 64'hDEADBEEF);
      check("tmo_err_now", 64'(timeoutErr), 64'd1);
      repeat (3) @(negedge clk);
      check("tmo_err_once", 64'(tmo_pulses - t0), 64'd1);
      ram_dead = 0;
    end
`endif

    // randomized traffic against the model
    do_reset();
    model_last = 1;
    fixed_lat = 0;
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 256; i++) mm[i] = mem[i];
      x0.delete(); x1.delete(); expq.delete();
      gen_ops(0, int'($urandom_range(8, 1)));
      gen_ops(1, int'($urandom_range(8, 0)));
      model_run();
      base = evlog.size();
      run_engine($sformatf("rand%0d", it));
      check($sformatf("rand%0d_count", it), 64'(evlog.size() - base), 64'(expq.size()));
      for (int i = 0; i < expq.size() && base + i < evlog.size(); i++) begin
        check($sformatf("rand%0d_port%0d", it, i), 64'(evlog[base + i].port), 64'(expq[i].port));
        check($sformatf("rand%0d_kind%0d", it, i), 64'(evlog[base + i].wr), 64'(expq[i].wr));
        check($sformatf("rand%0d_owner%0d", it, i), 64'(evlog[base + i].own), 64'(expq[i].port));
        if (!expq[i].wr)
          check($sformatf("rand%0d_data%0d", it, i), 64'(evlog[base + i].data), 64'(expq[i].data));
      end
    end

    // invariants gathered over the whole run
    check("never_read_and_write", 64'(both_viol), 64'd0);
    check("acks_only_to_owner", 64'(nonowner), 64'd0);
    check("ram_side_stable", 64'(unstable), 64'd0);
    check("req_gap_ge2", 64'(min_gap >= 2), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
